seg_scan_text_display: RTL and testbench

//  Parametrised multi-digit 7-segment text display for decoded Morse letters. Accepts 5-bit letter codes
//  (0=A..25=Z) through a valid/ready push port into an input FIFO. The FIFO drains into a shift-left digit

---
 rtl/seg_disp_pkg.sv | 44 ++++
 rtl/seg_scan_text_display_if.sv | 19 +
 rtl/seg_text_fifo.sv | 56 +++++
 rtl/seg_scan_text_display.sv | 99 +++++++++
 tb/tb_seg_scan_text_display.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_disp_pkg.sv
// Shared letter-code definitions and the active-high 7-segment glyph table
// for the Morse text display.
package seg_disp_pkg;

  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] BLANK_CODE = 5'd31;

  // Glyph bit order is {g,f,e,d,c,b,a}; codes 26..31 are blank.
  function automatic logic [6:0] glyph(input logic [CODE_W-1:0] code);
    logic [6:0] seg;
    seg = 7'b0000000;
    unique case (code)
      5'd0:  seg = 7'b1110111; // A
      5'd1:  seg = 7'b1111100; // b
      5'd2:  seg = 7'b0111001; // C
      5'd3:  seg = 7'b1011110; // d
      5'd4:  seg = 7'b1111001; // E
      5'd5:  seg = 7'b1110001; // F
      5'd6:  seg = 7'b0111101; // G
      5'd7:  seg = 7'b1110110; // H
      5'd8:  seg = 7'b0000110; // I
      5'd9:  seg = 7'b0011110; // J
      5'd10: seg = 7'b1110101; // K
      5'd11: seg = 7'b0111000; // L
      5'd12: seg = 7'b0110111; // M
      5'd13: seg = 7'b1010100; // n
      5'd14: seg = 7'b0111111; // O
      5'd15: seg = 7'b1110011; // P
      5'd16: seg = 7'b1100111; // q
      5'd17: seg = 7'b1010000; // r
      5'd18: seg = 7'b1101101; // S
      5'd19: seg = 7'b1111000; // t
      5'd20: seg = 7'b0111110; // U
      5'd21: seg = 7'b0011100; // v
      5'd22: seg = 7'b0101010; // W
      5'd23: seg = 7'b1100100; // X
      5'd24: seg = 7'b1101110; // y
      5'd25: seg = 7'b1011011; // Z
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_text_display_if.sv
// Push port, control inputs and display outputs of the scanned text display.
interface seg_scan_text_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int FIFO_DEPTH = 8
);
  import seg_disp_pkg::*;

  logic                          valid;
  logic [CODE_W-1:0]             data;
  logic                          ready;
  logic                          clear;
  logic                          scroll;
  logic [6:0]                    seg;
  logic [NUM_DIGITS-1:0]         digit;
  logic [$clog2(FIFO_DEPTH):0]   count;

  modport master (output valid, data, clear, scroll, input ready, seg, digit, count);
  modport slave  (input valid, data, clear, scroll, output ready, seg, digit, count);
endinterface

// File: rtl/seg_text_fifo.sv
// Synchronous letter FIFO with clear; read data is presented combinationally
// from the head so a pop can be consumed in the same clock.
module seg_text_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/seg_scan_text_display.sv
// Multi-digit 7-segment text display: FIFO-fed shift-left digit buffer,
// optional paced scrolling, and time-multiplexed scan onto one segment bus.
module seg_scan_text_display
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int SCROLL_DIV = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  seg_scan_text_display_if.slave  bus
);
  localparam int   SLOT_W = $clog2(SCAN_DIV);
  localparam int   IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   TMR_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic POL    = (ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF   = {7{POL}};
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = {NUM_DIGITS{POL}};
  localparam logic [NUM_DIGITS-1:0] DIGIT_ONE = 1;

  logic [CODE_W-1:0]           fifo_rd_data;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        drain_tick, pop_fire;
  logic [TMR_W-1:0]            tmr_reg;
  logic [CODE_W-1:0]           disp_reg [NUM_DIGITS];
  logic [SLOT_W-1:0]           slot_reg;
  logic [IDX_W-1:0]            idx_reg;
  logic [6:0]                  seg_reg;
  logic [NUM_DIGITS-1:0]       digit_reg;

  assign bus.ready  = !fifo_full && !bus.clear;
  assign bus.count  = fifo_count;
  assign bus.seg    = seg_reg;
  assign bus.digit  = digit_reg;
  assign drain_tick = !bus.scroll || (tmr_reg == TMR_W'(SCROLL_DIV - 1));
  assign pop_fire   = drain_tick && !fifo_empty && !bus.clear;

  seg_text_fifo #(.DEPTH(FIFO_DEPTH), .W(CODE_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.clear),
    .push    (bus.valid && bus.ready),
    .pop     (drain_tick),
    .wr_data (bus.data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Scroll pacing timer only runs while scrolling so each scroll session starts from a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           tmr_reg <= '0;
    else if (bus.clear || !bus.scroll) tmr_reg <= '0;
    else if (drain_tick)               tmr_reg <= '0;
    else                               tmr_reg <= tmr_reg + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    always_ff @(posedge clk or posedge rst) begin
      if (rst)            disp_reg[gi] <= BLANK_CODE;
      else if (bus.clear) disp_reg[gi] <= BLANK_CODE;
      else if (pop_fire) begin
        if (gi == 0) disp_reg[gi] <= fifo_rd_data;
        else         disp_reg[gi] <= disp_reg[(gi > 0) ? gi - 1 : 0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_reg <= '0;
      idx_reg  <= '0;
    end else if (slot_reg == SLOT_W'(SCAN_DIV - 1)) begin
      slot_reg <= '0;
      idx_reg  <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end else begin
      slot_reg <= slot_reg + 1'b1;
    end
  end

  // Slot count 0 is a blanking clock to hide ghosting while the digit switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_reg   <= SEG_OFF;
      digit_reg <= DIGIT_OFF;
    end else if (slot_reg == '0) begin
      seg_reg   <= SEG_OFF;
      digit_reg <= DIGIT_OFF;
    end else begin
      seg_reg   <= glyph(disp_reg[idx_reg]) ^ SEG_OFF;
      digit_reg <= (DIGIT_ONE << idx_reg) ^ DIGIT_OFF;
    end
  end
endmodule

// File: tb/tb_seg_scan_text_display.sv
// Directed bench for the scanned text display; accepted letters go to a
// scoreboard queue and are compared against what each digit slot shows.
module tb_seg_scan_text_display;
  import seg_disp_pkg::*;

  localparam int ND = 4;
  localparam int FD = 4;
  localparam int SD = 4;
  localparam int RD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_text_display_if #(.NUM_DIGITS(ND), .FIFO_DEPTH(FD)) bus ();

  seg_scan_text_display #(
    .NUM_DIGITS(ND), .FIFO_DEPTH(FD), .SCAN_DIV(SD), .SCROLL_DIV(RD), .ACTIVE_LOW(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Clocks since reset release, used to predict the scan position.
  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] disp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [4:0] c);
    logic [6:0] s;
    case (c)
      5'd0:    s = ~7'b1110111;
      5'd4:    s = ~7'b1111001;
      5'd7:    s = ~7'b1110110;
      default: s = (c >= 5'd26) ? 7'h7F : ~glyph(c);
    endcase
    return s;
  endfunction

  task automatic check_scan(input string tag);
    int c;
    logic [3:0] ed;
    c = cyc;
    if (c == 0 || ((c - 1) % SD) == 0) ed = 4'hF;
    else ed = ~(4'b0001 << (((c - 1) / SD) % ND));
    chk({tag, "_digit"}, {28'd0, bus.digit}, {28'd0, ed});
    if (ed == 4'hF) chk({tag, "_blank_seg"}, {25'd0, bus.seg}, 32'h7F);
  endtask

  task automatic wait_slot(input int d, input string tag);
    bit found;
    logic [3:0] want;
    found = 1'b0;
    want = ~(4'b0001 << d);
    for (int i = 0; i < 4 * SD * ND; i++) begin
      @(negedge clk);
      if (bus.digit === want) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_slot_found"}, {31'd0, found}, 32'd1);
  endtask

  // Expected digit d = d-th most recent accepted code, blank if fewer.
  task automatic check_display(input string tag);
    logic [4:0] code;
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      code = (d < disp_q.size()) ? disp_q[disp_q.size() - 1 - d] : 5'd31;
      wait_slot(d, $sformatf("%s_d%0d", tag, d));
      chk($sformatf("%s_d%0d_seg", tag, d), {25'd0, bus.seg}, {25'd0, exp_seg(code)});
    end
    while (disp_q.size() > ND) void'(disp_q.pop_front());
  endtask

  task automatic push_one(input logic [4:0] code, input string tag);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.data  = code;
    #1;
    chk({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
    if (bus.ready) disp_q.push_back(code);
  endtask

  task automatic wait_drained(input string tag);
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.count == 0) begin
        drained = 1'b1;
        break;
      end
    end
    chk({tag, "_drained"}, {31'd0, drained}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int next_code;
    int acc_n;
    int last_rise;
    bus.valid  = 1'b0;
    bus.data   = '0;
    bus.clear  = 1'b0;
    bus.scroll = 1'b0;

    // Reset state, then blank scan cycling through all digits.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seg",   {25'd0, bus.seg},   32'h7F);
    chk("rst_digit", {28'd0, bus.digit}, 32'hF);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_count", {29'd0, bus.count}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_scan("t1");
      chk("t1_seg",   {25'd0, bus.seg},   32'h7F);
      chk("t1_ready", {31'd0, bus.ready}, 32'd1);
      chk("t1_count", {29'd0, bus.count}, 32'd0);
    end

    // Immediate drain: A then E.
    push_one(5'd0, "t2_a");
    push_one(5'd4, "t2_e");
    @(negedge clk);
    bus.valid = 1'b0;
    check_display("t2");
    chk("t2_count", {29'd0, bus.count}, 32'd0);

    // Scrolling with continuous push of codes 0..5; full FIFO refuses pushes.
    @(negedge clk);
    bus.scroll = 1'b1;
    bus.valid  = 1'b1;
    next_code  = 0;
    acc_n      = 0;
    last_rise  = -1;
    for (int i = 0; i < 200 && next_code < 6; i++) begin
      bus.data = 5'(next_code);
      #1;
      if (bus.ready) begin
        if (acc_n >= FD) begin
          chk("t4_count_after_pop", {29'd0, bus.count}, 32'd3);
          if (last_rise >= 0) chk("t3_pop_spacing", cyc - last_rise, RD);
          last_rise = cyc;
        end
        disp_q.push_back(5'(next_code));
        next_code++;
        acc_n++;
      end else begin
        chk("t3_full_count", {29'd0, bus.count}, 32'd4);
      end
      @(negedge clk);
    end
    bus.valid = 1'b0;
    chk("t3_all_accepted", next_code, 6);
    wait_drained("t3");
    check_display("t3");

    // Clear while scrolling with a push pending.
    push_one(5'd7, "t5_h");
    push_one(5'd0, "t5_a");
    @(negedge clk);
    bus.clear = 1'b1;
    bus.valid = 1'b1;
    bus.data  = 5'd7;
    #1;
    chk("t5_ready_clear", {31'd0, bus.ready}, 32'd0);
    check_scan("t5_pre");
    @(negedge clk);
    bus.clear = 1'b0;
    bus.valid = 1'b0;
    disp_q.delete();
    chk("t5_count", {29'd0, bus.count}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check_scan("t5_post");
      chk("t5_count_hold", {29'd0, bus.count}, 32'd0);
      @(negedge clk);
    end
    check_display("t5");

    // Async reset mid-slot while a letter is visible.
    bus.scroll = 1'b0;
    push_one(5'd7, "t6_h");
    push_one(5'd27, "t6_blank");
    @(negedge clk);
    bus.valid = 1'b0;
    check_display("t6_pre");
    wait_slot(1, "t6_mid");
    chk("t6_pre_rst_seg", {25'd0, bus.seg}, {25'd0, exp_seg(5'd7)});
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_seg",   {25'd0, bus.seg},   32'h7F);
    chk("t6_rst_digit", {28'd0, bus.digit}, 32'hF);
    chk("t6_rst_count", {29'd0, bus.count}, 32'd0);
    disp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_display("t6_post");
    chk("t6_post_count", {29'd0, bus.count}, 32'd0);
    chk("t6_post_ready", {31'd0, bus.ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
